// File: rtl/lsu_pkg.sv
// LSU shared definitions: access-type encodings, FSM states, address checks.
// LSU_MISALIGN_TRAP_EN (see lsu.sv) uses is_misaligned() from here.
package lsu_pkg;

    localparam logic [2:0] LSU_W  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_HU = 3'b010;
    localparam logic [2:0] LSU_B  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    function automatic logic is_valid_type(input logic [2:0] t);
        return t <= LSU_BU;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t,
                                           input logic [1:0] a);
        logic r;
        r = 1'b0;
        if (t == LSU_W)
            r = (a != 2'b00);
        else if (t == LSU_H || t == LSU_HU)
            r = a[0];
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / write data and load extraction.
// Offending low address bits are dropped: words use lane 0, halves addr[1].
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  req_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata
);

    logic [1:0]  off;
    logic [31:0] lane;

    always_comb begin
        off     = 2'b00;
        be      = 4'b0000;
        wdata_o = 32'h0;
        case (req_type)
            LSU_W: begin
                be      = 4'b1111;
                wdata_o = wdata;
            end
            LSU_H, LSU_HU: begin
                off     = {addr_lo[1], 1'b0};
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata[15:0]}};
            end
            LSU_B, LSU_BU: begin
                off     = addr_lo;
                be      = 4'b0001 << addr_lo;
                wdata_o = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        ldata = 32'h0;
        case (req_type)
            LSU_W:   ldata = lane;
            LSU_H:   ldata = {{16{lane[15]}}, lane[15:0]};
            LSU_HU:  ldata = {16'h0, lane[15:0]};
            LSU_B:   ldata = {{24{lane[7]}}, lane[7:0]};
            LSU_BU:  ldata = {24'h0, lane[7:0]};
            default: ldata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access, IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              stall,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [3:0]        be;
    logic [31:0]       ld;
    logic              accept;
    logic              bad_addr;

    lsu_align u_align (
        .req_type (type_q),
        .addr_lo  (addr_q[1:0]),
        .wdata    (wdata_q),
        .rdata    (mem_rdata),
        .be       (be),
        .wdata_o  (mem_wdata),
        .ldata    (ld)
    );

    assign accept = req_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;

    assign bad_addr = is_misaligned(req_type, req_addr[1:0]);

    always_comb mis_d = accept && is_valid_type(req_type) && bad_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end

    assign misalign = mis_q;
`else
    assign bad_addr = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    type_d  = req_type;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    // unknown types skip memory; loads still answer with 0
                    if (!is_valid_type(req_type)) begin
                        rsp_data_d = 32'h0;
                        state_d    = req_we ? S_IDLE : S_RESP;
                    end else if (!bad_addr) begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    if (we_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rsp_data_d = ld;
                        state_d    = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            type_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            rsp_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign stall     = !req_ready;
    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be    = mem_en ? be : 4'b0000;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rd_q;

endmodule
